weight_fetch_sched: RTL and testbench
=====================================

// Module: weight_fetch_sched
// PURPOSE
//  Sequences DDR reads that fill the weight memory unit during a weight-load phase of the layer FSM.
//  - Converts the layer config (base address, number of weight groups) into bounded read bursts.
//  - Tracks the returned 256-bit beats.
//  - Pulses state_rst/load_done back to the top-level FSM when the load completes.
//  - Sits between the layer FSM (current_state), the DDR read front-end and the weight memory unit.
// PARAMETERS
//  DDR_RD_WIDTH          256    DDR read beat width, bits
//  WEIGHT_CHANNEL_WIDTH  1296   bits per weight group; BEATS_PER_GROUP = ceil(WCW/DRW) = 6 (localparam)
//  ADDR_WIDTH            32     DDR byte address width
//  BURST_MAX             16     max beats per read command (1..255)
//  CNT_WIDTH             16     width of cfg_group_num
//  LOAD_STATE            3'd1   current_state encoding that means "load weights"
// PORTS
//  clk              in   1             system clock
//  rstn             in   1             async active-low reset
//  current_state    in   3             layer FSM state
//  cfg_base_addr    in   ADDR_WIDTH    weight base byte address; sampled at start
//  cfg_group_num    in   CNT_WIDTH     weight groups to load; sampled at start
//  rd_cmd_valid     out  1             read command request
//  rd_cmd_ready     in   1             front-end accepts command
//  rd_cmd_addr      out  ADDR_WIDTH    burst start byte address
//  rd_cmd_len       out  8             burst length in beats (1..BURST_MAX)
//  DDR_valid_in     in   1             one read beat returned this cycle
//  load_busy        out  1             high in CMD/DATA/DRAIN
//  load_done        out  1             1-cycle pulse on completion
//  state_rst        out  1             same pulse as load_done, to layer FSM
//  err_overrun      out  1             sticky: beat seen with no burst outstanding
// BEHAVIOUR
//  Reset
//  - All outputs 0; FSM = IDLE; counters 0; prev-state register = 0.
//  Start
//  - Registered edge: current_state==LOAD_STATE && prev_state!=LOAD_STATE, in IDLE only.
//  - At start: latch base addr; rem_beats = cfg_group_num*BEATS_PER_GROUP (CNT_WIDTH+3 bits); clear err_overrun.
//  - If cfg_group_num==0, go to DONE; otherwise go to CMD.
//  CMD
//  - rd_cmd_valid=1, rd_cmd_len=min(BURST_MAX, rem_beats), rd_cmd_addr=cur_addr.
//  - Outputs hold stable until rd_cmd_valid&&rd_cmd_ready.
//  - On handshake: cur_addr += len*(DDR_RD_WIDTH/8); rem_beats -= len; beat_cnt=0; go to DATA.
//  - Exactly one burst is outstanding at any time.
//  DATA
//  - beat_cnt++ on each DDR_valid_in.
//  - On the beat that makes beat_cnt==len: go to DONE if rem_beats==0, else go to CMD.
//  DONE
//  - Lasts 1 cycle: load_done=state_rst=1, then go to IDLE.
//  Abort
//  - current_state!=LOAD_STATE while busy.
//  - From CMD: drop rd_cmd_valid, go to IDLE. The front-end samples valid only together with ready.
//  - From DATA: go to DRAIN. DRAIN swallows the remaining beats of the current burst, then goes to IDLE. No done pulse.
//  - Abort has priority over the last-beat transition in the same cycle. If that beat completes the burst, go directly to IDLE.
//  Error
//  - DDR_valid_in in IDLE, CMD or DONE sets err_overrun. The beat is ignored.
//  - Cleared only by rstn or the next start.
//  Other rules
//  - A start edge is ignored while not in IDLE.
//  - Address wraps modulo 2^ADDR_WIDTH.
//  - Reset mid-operation returns everything to reset values immediately (async).
// TESTING
//  T1
//  - Stimulus: base=0x1000, groups=1, ready=1.
//  - Response: one cmd addr=0x1000 len=6; after the 6th beat, load_done=state_rst=1 for exactly 1 cycle.
//  T2
//  - Stimulus: groups=5 (30 beats).
//  - Response: cmds len=16 @0x1000, then len=14 @0x1200; single done after beat 30.
//  T3
//  - Stimulus: groups=0.
//  - Response: no rd_cmd_valid; done pulse in the cycle after the start edge.
//  T4
//  - Stimulus: rd_cmd_ready low for 10 cycles.
//  - Response: rd_cmd_valid, addr and len held constant; no state change.
//  T5
//  - Stimulus: current_state leaves LOAD_STATE after 3 of 16 beats.
//  - Response: DRAIN absorbs 13 beats, returns to IDLE, no done, err_overrun=0.
//  T6
//  - Stimulus: DDR_valid_in pulse in IDLE.
//  - Response: err_overrun=1 and stays set until the next start; rstn low mid-DATA clears all outputs.

Source files
------------

// File: rtl/weight_fetch_sched.sv
// Weight-load read scheduler: splits a layer's weight groups into bounded DDR read bursts,
// counts returned beats, and pulses load_done/state_rst to the layer FSM when the load completes.
module weight_fetch_sched #(
    parameter int unsigned DDR_RD_WIDTH         = 256,
    parameter int unsigned WEIGHT_CHANNEL_WIDTH = 1296,
    parameter int unsigned ADDR_WIDTH           = 32,
    parameter int unsigned BURST_MAX            = 16,
    parameter int unsigned CNT_WIDTH            = 16,
    parameter logic [2:0]  LOAD_STATE           = 3'd1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [2:0]            current_state,
    input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
    input  logic [CNT_WIDTH-1:0]  cfg_group_num,
    output logic                  rd_cmd_valid,
    input  logic                  rd_cmd_ready,
    output logic [ADDR_WIDTH-1:0] rd_cmd_addr,
    output logic [7:0]            rd_cmd_len,
    input  logic                  DDR_valid_in,
    output logic                  load_busy,
    output logic                  load_done,
    output logic                  state_rst,
    output logic                  err_overrun
);

    localparam int unsigned BEATS_PER_GROUP =
        (WEIGHT_CHANNEL_WIDTH + DDR_RD_WIDTH - 1) / DDR_RD_WIDTH;
    localparam int unsigned REM_W = CNT_WIDTH + 3;
    localparam logic [REM_W-1:0]      BURST_MAX_REM = REM_W'(BURST_MAX);
    localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES    = ADDR_WIDTH'(DDR_RD_WIDTH / 8);

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StData,
        StDrain,
        StDone
    } state_e;

    state_e                state_q;
    logic [2:0]            prev_state_q;
    logic [ADDR_WIDTH-1:0] cur_addr_q;
    logic [REM_W-1:0]      rem_beats_q;
    logic [7:0]            beat_cnt_q;

    logic             start;
    logic             abort;
    logic             last_beat;
    logic [7:0]       beat_cnt_inc;
    logic [REM_W-1:0] start_rem;

    function automatic logic [7:0] burst_len(input logic [REM_W-1:0] rem);
        return (rem > BURST_MAX_REM) ? 8'(BURST_MAX) : rem[7:0];
    endfunction

    assign start        = (state_q == StIdle) && (current_state == LOAD_STATE)
                          && (prev_state_q != LOAD_STATE);
    assign abort        = (current_state != LOAD_STATE);
    assign start_rem    = REM_W'(cfg_group_num) * REM_W'(BEATS_PER_GROUP);
    assign beat_cnt_inc = beat_cnt_q + 8'd1;
    // rd_cmd_len still holds the length of the burst in flight during DATA/DRAIN
    assign last_beat    = DDR_valid_in && (beat_cnt_inc == rd_cmd_len);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= StIdle;
            prev_state_q <= 3'd0;
            cur_addr_q   <= '0;
            rem_beats_q  <= '0;
            beat_cnt_q   <= 8'd0;
            rd_cmd_valid <= 1'b0;
            rd_cmd_addr  <= '0;
            rd_cmd_len   <= 8'd0;
            load_busy    <= 1'b0;
            load_done    <= 1'b0;
            state_rst    <= 1'b0;
            err_overrun  <= 1'b0;
        end else begin
            prev_state_q <= current_state;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        err_overrun <= 1'b0;
                        cur_addr_q  <= cfg_base_addr;
                        rem_beats_q <= start_rem;
                        if (cfg_group_num == '0) begin
                            state_q   <= StDone;
                            load_done <= 1'b1;
                            state_rst <= 1'b1;
                        end else begin
                            state_q      <= StCmd;
                            rd_cmd_valid <= 1'b1;
                            rd_cmd_addr  <= cfg_base_addr;
                            rd_cmd_len   <= burst_len(start_rem);
                            load_busy    <= 1'b1;
                        end
                    end
                    // A stray beat is still an overrun even if it lands on the start cycle
                    if (DDR_valid_in) begin
                        err_overrun <= 1'b1;
                    end
                end
                StCmd: begin
                    if (DDR_valid_in) begin
                        err_overrun <= 1'b1;
                    end
                    if (abort) begin
                        state_q      <= StIdle;
                        rd_cmd_valid <= 1'b0;
                        load_busy    <= 1'b0;
                    end else if (rd_cmd_ready) begin
                        state_q      <= StData;
                        rd_cmd_valid <= 1'b0;
                        cur_addr_q   <= cur_addr_q + ADDR_WIDTH'(rd_cmd_len) * BEAT_BYTES;
                        rem_beats_q  <= rem_beats_q - REM_W'(rd_cmd_len);
                        beat_cnt_q   <= 8'd0;
                    end
                end
                StData: begin
                    if (DDR_valid_in) begin
                        beat_cnt_q <= beat_cnt_inc;
                    end
                    if (abort) begin
                        if (last_beat) begin
                            state_q   <= StIdle;
                            load_busy <= 1'b0;
                        end else begin
                            state_q <= StDrain;
                        end
                    end else if (last_beat) begin
                        if (rem_beats_q == '0) begin
                            state_q   <= StDone;
                            load_busy <= 1'b0;
                            load_done <= 1'b1;
                            state_rst <= 1'b1;
                        end else begin
                            state_q      <= StCmd;
                            rd_cmd_valid <= 1'b1;
                            rd_cmd_addr  <= cur_addr_q;
                            rd_cmd_len   <= burst_len(rem_beats_q);
                        end
                    end
                end
                StDrain: begin
                    if (DDR_valid_in) begin
                        beat_cnt_q <= beat_cnt_inc;
                    end
                    if (last_beat) begin
                        state_q   <= StIdle;
                        load_busy <= 1'b0;
                    end
                end
                StDone: begin
                    if (DDR_valid_in) begin
                        err_overrun <= 1'b1;
                    end
                    state_q   <= StIdle;
                    load_done <= 1'b0;
                    state_rst <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_weight_fetch_sched.sv
// Bench for weight_fetch_sched: directed table, multi-cycle corner sequences and randomized loads
// checked against a burst-list model built from the group count and base address.
module tb_weight_fetch_sched;

    localparam logic [2:0] LOAD = 3'd1;
    localparam logic [2:0] OTHER = 3'd2;

    logic        clk;
    logic        rstn;
    logic [2:0]  current_state;
    logic [31:0] cfg_base_addr;
    logic [15:0] cfg_group_num;
    logic        rd_cmd_valid;
    logic        rd_cmd_ready;
    logic [31:0] rd_cmd_addr;
    logic [7:0]  rd_cmd_len;
    logic        DDR_valid_in;
    logic        load_busy;
    logic        load_done;
    logic        state_rst;
    logic        err_overrun;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_addr_q[$];
    logic [7:0]  exp_len_q[$];

    weight_fetch_sched dut (
        .clk           (clk),
        .rstn          (rstn),
        .current_state (current_state),
        .cfg_base_addr (cfg_base_addr),
        .cfg_group_num (cfg_group_num),
        .rd_cmd_valid  (rd_cmd_valid),
        .rd_cmd_ready  (rd_cmd_ready),
        .rd_cmd_addr   (rd_cmd_addr),
        .rd_cmd_len    (rd_cmd_len),
        .DDR_valid_in  (DDR_valid_in),
        .load_busy     (load_busy),
        .load_done     (load_done),
        .state_rst     (state_rst),
        .err_overrun   (err_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] base;
        logic [15:0] groups;
        int          ncmd;
        logic [31:0] last_addr;
        logic [7:0]  last_len;
    } vec_t;

    vec_t vecs[5];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic outs_zero(input string tag);
        chk({tag, "_valid"}, rd_cmd_valid, 0);
        chk({tag, "_addr"}, rd_cmd_addr, 0);
        chk({tag, "_len"}, rd_cmd_len, 0);
        chk({tag, "_busy"}, load_busy, 0);
        chk({tag, "_done"}, load_done, 0);
        chk({tag, "_srst"}, state_rst, 0);
        chk({tag, "_err"}, err_overrun, 0);
    endtask

    // Acts as DDR front-end for one full load; burst list comes from the plain-arithmetic model.
    task automatic run_load(input logic [31:0] base, input logic [15:0] groups,
                            input int ready_pct, input int beat_pct, output int ncmd,
                            output logic [31:0] last_addr, output logic [7:0] last_len);
        int          total;
        int          pending;
        int          l;
        logic [31:0] a;
        bit          done_seen;
        exp_addr_q.delete();
        exp_len_q.delete();
        total = int'(groups) * 6;
        a = base;
        while (total > 0) begin
            l = (total > 16) ? 16 : total;
            exp_addr_q.push_back(a);
            exp_len_q.push_back(8'(l));
            a = a + 32'(l * 32);
            total = total - l;
        end
        ncmd = 0;
        last_addr = 0;
        last_len = 0;
        pending = 0;
        done_seen = 0;
        cfg_base_addr = base;
        cfg_group_num = groups;
        current_state = LOAD;
        DDR_valid_in = 0;
        rd_cmd_ready = 0;
        step();
        for (int cyc = 0; cyc < 3000 && !done_seen; cyc++) begin
            DDR_valid_in = 0;
            rd_cmd_ready = 0;
            chk("err_during_load", err_overrun, 0);
            if (load_done) begin
                done_seen = 1;
                chk("done_cmds_left", exp_addr_q.size(), 0);
                chk("done_beats_left", pending, 0);
                chk("done_state_rst", state_rst, 1);
                chk("done_busy", load_busy, 0);
                chk("done_valid", rd_cmd_valid, 0);
            end else begin
                chk("busy", load_busy, 1);
                chk("srst_early", state_rst, 0);
                if (rd_cmd_valid) begin
                    chk("valid_no_pending", pending, 0);
                    if (exp_addr_q.size() == 0) begin
                        chk("extra_cmd", 1, 0);
                    end else begin
                        chk("cmd_addr", rd_cmd_addr, exp_addr_q[0]);
                        chk("cmd_len", rd_cmd_len, exp_len_q[0]);
                        rd_cmd_ready = ($urandom % 100) < ready_pct;
                        if (rd_cmd_ready) begin
                            ncmd++;
                            last_addr = exp_addr_q.pop_front();
                            last_len = exp_len_q.pop_front();
                            pending = int'(last_len);
                        end
                    end
                end else if (pending > 0) begin
                    DDR_valid_in = ($urandom % 100) < beat_pct;
                    if (DDR_valid_in) pending--;
                end
                step();
            end
        end
        if (!done_seen) chk("load_timeout", 0, 1);
        DDR_valid_in = 0;
        rd_cmd_ready = 0;
        current_state = 3'd0;
        step();
        chk("done_one_cycle", load_done, 0);
        chk("idle_busy", load_busy, 0);
    endtask

    initial begin
        int          nc;
        logic [31:0] la;
        logic [7:0]  ll;
        logic [31:0] held_addr;
        logic [7:0]  held_len;
        int          done_cnt;

        vecs[0] = '{32'h0000_1000, 16'd1, 1, 32'h0000_1000, 8'd6};
        vecs[1] = '{32'h0000_1000, 16'd5, 2, 32'h0000_1200, 8'd14};
        vecs[2] = '{32'h0000_1000, 16'd0, 0, 32'h0000_0000, 8'd0};
        vecs[3] = '{32'hFFFF_FFE0, 16'd3, 2, 32'h0000_01E0, 8'd2};
        vecs[4] = '{32'h0000_2000, 16'd8, 3, 32'h0000_2400, 8'd16};

        rstn = 0;
        current_state = 3'd0;
        cfg_base_addr = 0;
        cfg_group_num = 0;
        rd_cmd_ready = 0;
        DDR_valid_in = 0;
        repeat (2) @(posedge clk);
        #1;
        outs_zero("reset");
        rstn = 1;
        step();

        foreach (vecs[i]) begin
            run_load(vecs[i].base, vecs[i].groups, 100, 100, nc, la, ll);
            chk($sformatf("vec%0d_ncmd", i), nc, vecs[i].ncmd);
            chk($sformatf("vec%0d_last_addr", i), la, vecs[i].last_addr);
            chk($sformatf("vec%0d_last_len", i), ll, vecs[i].last_len);
        end

        // Command held stable while ready stays low
        cfg_base_addr = 32'h0000_3000;
        cfg_group_num = 16'd1;
        current_state = LOAD;
        step();
        chk("hold_valid0", rd_cmd_valid, 1);
        held_addr = rd_cmd_addr;
        held_len = rd_cmd_len;
        chk("hold_addr0", held_addr, 32'h0000_3000);
        chk("hold_len0", held_len, 6);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("hold_valid", rd_cmd_valid, 1);
            chk("hold_addr", rd_cmd_addr, held_addr);
            chk("hold_len", rd_cmd_len, held_len);
        end
        rd_cmd_ready = 1;
        step();
        rd_cmd_ready = 0;
        repeat (6) begin
            DDR_valid_in = 1;
            step();
        end
        DDR_valid_in = 0;
        chk("hold_done", load_done, 1);
        current_state = 3'd0;
        step();

        // Abort from CMD
        cfg_group_num = 16'd2;
        current_state = LOAD;
        step();
        chk("abort_cmd_valid_pre", rd_cmd_valid, 1);
        current_state = OTHER;
        step();
        chk("abort_cmd_valid", rd_cmd_valid, 0);
        chk("abort_cmd_busy", load_busy, 0);
        step();
        chk("abort_cmd_done", load_done, 0);

        // Abort after 3 of 16 beats: drain swallows 13
        current_state = 3'd0;
        step();
        cfg_base_addr = 32'h0000_4000;
        cfg_group_num = 16'd3;
        current_state = LOAD;
        step();
        chk("drain_first_len", rd_cmd_len, 16);
        rd_cmd_ready = 1;
        step();
        rd_cmd_ready = 0;
        repeat (3) begin
            DDR_valid_in = 1;
            step();
        end
        DDR_valid_in = 0;
        current_state = OTHER;
        step();
        chk("drain_busy_entry", load_busy, 1);
        done_cnt = 0;
        repeat (12) begin
            DDR_valid_in = 1;
            step();
            if (load_done) done_cnt++;
        end
        DDR_valid_in = 0;
        chk("drain_busy_15", load_busy, 1);
        DDR_valid_in = 1;
        step();
        DDR_valid_in = 0;
        if (load_done) done_cnt++;
        chk("drain_busy_end", load_busy, 0);
        chk("drain_no_done", done_cnt, 0);
        chk("drain_err", err_overrun, 0);
        repeat (3) step();
        chk("drain_no_cmd", rd_cmd_valid, 0);

        // Abort on the burst's final beat goes straight to idle without done
        current_state = 3'd0;
        step();
        cfg_group_num = 16'd1;
        current_state = LOAD;
        step();
        rd_cmd_ready = 1;
        step();
        rd_cmd_ready = 0;
        repeat (5) begin
            DDR_valid_in = 1;
            step();
        end
        DDR_valid_in = 1;
        current_state = OTHER;
        step();
        DDR_valid_in = 0;
        chk("abort_last_busy", load_busy, 0);
        chk("abort_last_done", load_done, 0);
        step();
        chk("abort_last_done2", load_done, 0);
        chk("abort_last_err", err_overrun, 0);

        // Stray beat in idle sets sticky error until next start
        DDR_valid_in = 1;
        step();
        DDR_valid_in = 0;
        chk("err_set", err_overrun, 1);
        repeat (5) step();
        chk("err_sticky", err_overrun, 1);
        cfg_group_num = 16'd1;
        cfg_base_addr = 32'h0000_5000;
        current_state = 3'd0;
        step();
        chk("err_sticky2", err_overrun, 1);
        current_state = LOAD;
        step();
        chk("err_cleared", err_overrun, 0);
        rd_cmd_ready = 1;
        step();
        rd_cmd_ready = 0;
        repeat (2) begin
            DDR_valid_in = 1;
            step();
        end
        DDR_valid_in = 0;
        chk("rst_mid_busy_pre", load_busy, 1);
        #2 rstn = 0;
        #1;
        outs_zero("rst_mid");
        @(posedge clk);
        #1;
        current_state = 3'd0;
        rstn = 1;
        step();
        outs_zero("after_rst");

        for (int i = 0; i < 12; i++) begin
            run_load($urandom, 16'($urandom_range(0, 9)), $urandom_range(20, 100),
                     $urandom_range(30, 100), nc, la, ll);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
